// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding,
// requester count and index width.
package rr_arbiter8_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    // Highest requester index; requester i sits on req bit (MAX_IDX - i).
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : rr_arbiter8_pkg

// File: rtl/rr_arbiter8_decoder38.sv
// 3-to-8 one-hot decoder, MSB-first: index 0 drives bit 7.
// The output is all zero while en is low.
module decoder38
    import rr_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    // Shift a single MSB marker down by the index, gated by enable.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = {1'b1, {(NUM_REQ-1){1'b0}}} >> idx;
        end
    end

endmodule : decoder38

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time.
// A grant is issued one cycle after a request is seen in IDLE, held until
// done, loss of the grantee's own request, or the hold limit, and is always
// followed by at least one dead cycle. Requester i drives req[7-i].
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] id_q;
    logic [IDX_W-1:0] id_next;
    logic [7:0]       hold_cnt;
    logic [7:0]       hold_next;

    logic [IDX_W-1:0] winner;
    logic             found;
    logic [IDX_W-1:0] cand;
    logic             release_now;

    // Priority scan: first requesting index at or above ptr, wrapping mod 8.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[MAX_IDX - cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Release when the grantee finishes, withdraws, or hits the hold limit.
    always_comb begin
        release_now = done
                    || !req[MAX_IDX - id_q]
                    || (hold_cnt == HOLD_LAST);
    end

    // Next-state logic: IDLE always lasts at least one cycle between grants.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        id_next    = id_q;
        hold_next  = hold_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    id_next    = winner;
                    hold_next  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_next = IDLE;
                    ptr_next   = id_q + IDX_W'(1);
                end else begin
                    hold_next  = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, pointer, grantee and hold counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            id_q     <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            id_q     <= id_next;
            hold_cnt <= hold_next;
        end
    end

    assign busy   = (state == GRANT);
    assign gnt_id = id_q;

    decoder38 u_decoder38 (
        .idx    (id_q),
        .en     (busy),
        .onehot (gnt)
    );

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: stimulus pushes expected grants
// (id, length, preceding idle gap) and a negedge monitor checks each grant
// the DUT presents against the head of the queue.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;

    typedef struct {
        int unsigned id;
        int unsigned len;   // 0 = not checked
        int unsigned gap;   // 0 = not checked
    } exp_t;

    exp_t sb[$];

    int unsigned total = 0;
    int unsigned bad   = 0;

    rr_arbiter8 #(.HOLD_MAX(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int unsigned id, input int unsigned len, input int unsigned gap);
        exp_t e;
        e.id  = id;
        e.len = len;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Called one step after a grant's entry edge; releases it via done so
    // the grant lasts exactly `cycles` cycles.
    task automatic hold_then_done(input int unsigned cycles);
        step(cycles - 1);
        done = 1'b1;
        step(1);
        done = 1'b0;
    endtask

    // Monitor: compare every presented grant against the scoreboard.
    initial begin : monitor
        logic        prev_busy;
        int unsigned cur_len;
        int unsigned idle_cnt;
        logic [7:0]  onehot;
        exp_t        cur;
        prev_busy = 1'b0;
        cur_len   = 0;
        idle_cnt  = 0;
        cur.id = 0; cur.len = 0; cur.gap = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy_vs_gnt", {31'd0, busy}, {31'd0, (gnt != 8'h00)});
                if (busy && !prev_busy) begin
                    if (sb.size() == 0) begin
                        check("unexpected_grant", {29'd0, gnt_id}, 32'hFFFF_FFFF);
                    end else begin
                        cur = sb.pop_front();
                        onehot = 8'h80 >> cur.id;
                        check("grant_id", {29'd0, gnt_id}, cur.id);
                        check("grant_vec", {24'd0, gnt}, {24'd0, onehot});
                        if (cur.gap != 0)
                            check("dead_gap", idle_cnt, cur.gap);
                    end
                    cur_len = 1;
                end else if (busy && prev_busy) begin
                    cur_len++;
                    check("grant_hold", {29'd0, gnt_id}, cur.id);
                end else if (!busy && prev_busy) begin
                    if (cur.len != 0)
                        check("grant_len", cur_len, cur.len);
                    idle_cnt = 1;
                end else begin
                    idle_cnt++;
                end
                prev_busy = busy;
            end else begin
                prev_busy = 1'b0;
                idle_cnt  = 0;
            end
        end
    end

    initial begin : stimulus
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        #2;
        check("rst_gnt", {24'd0, gnt}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_gnt_id", {29'd0, gnt_id}, 32'h0);
        step(2);
        rst = 1'b0;

        // Requesters 0 and 2: 0 first, then 2 after one dead cycle.
        req = 8'b1010_0000;
        expect_grant(0, 2, 0);
        step(1);
        hold_then_done(2);
        expect_grant(2, 3, 1);
        step(1);
        hold_then_done(3);
        req = 8'h00;                       // ptr = 3

        // done while idle is ignored; ptr stays 3 so requester 3 beats 0.
        done = 1'b1;
        step(2);
        done = 1'b0;
        req = 8'b1001_0000;
        expect_grant(3, 2, 0);
        step(1);
        step(1);
        req = 8'b1000_0000;                // grantee 3 withdraws in cycle 2
        step(1);
        req = 8'b1001_1000;                // ptr = 4 -> requester 4 wins
        expect_grant(4, 3, 1);
        step(1);
        hold_then_done(3);                 // ptr = 5

        // Async reset mid-grant drops gnt before the next edge.
        req = 8'hFF;
        expect_grant(5, 0, 1);
        step(1);
        step(1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gnt", {24'd0, gnt}, 32'h0);
        check("async_rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        req = 8'b0000_0011;                // ptr = 0 -> requester 6
        expect_grant(6, 2, 0);
        step(1);
        hold_then_done(2);                 // ptr = 7

        // Sole requester 7, no done: 16-cycle timeout then regrant.
        req = 8'b0000_0001;
        expect_grant(7, 16, 1);
        step(1);
        step(16);
        expect_grant(7, 16, 1);
        step(1);
        step(15);
        done = 1'b1;                       // coincides with timeout edge
        step(1);
        done = 1'b0;
        expect_grant(7, 3, 1);
        step(1);
        hold_then_done(3);                 // ptr = 0
        req = 8'h00;
        step(2);

        // All requesting: order 0..7 then 0 again.
        req = 8'hFF;
        for (int unsigned i = 0; i < 9; i++) begin
            expect_grant(i % 8, 3, (i == 0) ? 0 : 1);
            step(1);
            hold_then_done(3);
        end
        req = 8'h00;
        step(3);

        check("scoreboard_drained", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rr_arbiter8
